// File: rtl/lc3_mem_ctrl_pkg.sv
// Shared types and constants for the LC-3 memory controller slice.
// Holds the memory-cycle state encoding, the R_W meanings and the wait-counter width.
package lc3_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        FINISH = 2'd2
    } mem_state_t;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    localparam int CNT_W = 8;

endpackage

// File: rtl/lc3_mem_ctrl_ld_reg.sv
// Width-parametrised load-enable register with synchronous active-high reset.
// Used for both MAR and MDR.
module lc3_ld_reg #(
    parameter int W = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         i_ld,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_q <= '0;
        end else if (i_ld) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/lc3_mem_ctrl.sv
// MAR/MDR pair plus memory-cycle FSM (IDLE -> ACCESS -> FINISH) between the CPU bus and SRAM/IO.
// Handshake: i_Req is a one-cycle start sampled only in IDLE; o_Done is a one-cycle completion pulse.
module lc3_mem_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int WAIT_CYCLES = 2,
    parameter int USE_READY   = 0,
    parameter int TIMEOUT     = 64
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] i_Bus_In,
    input  logic              i_LD_MAR,
    input  logic              i_LD_MDR,
    input  logic              i_Req,
    input  logic              i_R_W,
    input  logic [DATA_W-1:0] i_Mem_RData,
    input  logic              i_Mem_Ready,
    output logic [ADDR_W-1:0] o_MAR,
    output logic [DATA_W-1:0] o_MDR,
    output logic [ADDR_W-1:0] o_Mem_Addr,
    output logic [DATA_W-1:0] o_Mem_WData,
    output logic              o_Mem_CE,
    output logic              o_Mem_WE,
    output logic              o_Busy,
    output logic              o_Done,
    output logic              o_Err,
    output mem_state_t        o_dbg_state
);

    localparam logic [CNT_W-1:0] WAIT_LAST    = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_t        r_state;
    mem_state_t        w_next_state;
    logic              r_rw;
    logic              r_err;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_idle;
    logic              w_end;
    logic              w_timeout;
    logic              w_capture;
    logic              w_mar_ld;
    logic              w_mdr_ld;
    logic [DATA_W-1:0] w_mdr_d;
    logic [ADDR_W-1:0] w_mar_q;
    logic [DATA_W-1:0] w_mdr_q;

    assign w_idle = (r_state == IDLE);

    always_comb begin
        w_next_state = r_state;
        w_end        = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_Req) begin
                    w_next_state = ACCESS;
                end
            end
            ACCESS: begin
                // Ready wins over the timeout when both land in the same cycle.
                if (USE_READY != 0) begin
                    if (i_Mem_Ready) begin
                        w_end = 1'b1;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        w_end     = 1'b1;
                        w_timeout = 1'b1;
                    end
                end else if (r_cnt == WAIT_LAST) begin
                    w_end = 1'b1;
                end
                if (w_end) begin
                    w_next_state = FINISH;
                end
            end
            FINISH: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
            r_rw    <= MEM_READ;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_idle) begin
                r_err <= 1'b0;
                if (i_Req) begin
                    r_rw  <= i_R_W;
                    r_cnt <= '0;
                end
            end else if (r_state == ACCESS) begin
                r_err <= w_timeout;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Memory capture has priority over the CPU-side MDR load.
    assign w_capture = (r_state == ACCESS) && w_end && !w_timeout && (r_rw == MEM_READ);
    assign w_mar_ld  = w_idle && i_LD_MAR;
    assign w_mdr_ld  = w_capture || (w_idle && i_LD_MDR);
    assign w_mdr_d   = w_capture ? i_Mem_RData : i_Bus_In;

    lc3_ld_reg #(.W(ADDR_W)) u_mar (
        .Clk   (Clk),
        .Reset (Reset),
        .i_ld  (w_mar_ld),
        .i_d   (i_Bus_In[ADDR_W-1:0]),
        .o_q   (w_mar_q)
    );

    lc3_ld_reg #(.W(DATA_W)) u_mdr (
        .Clk   (Clk),
        .Reset (Reset),
        .i_ld  (w_mdr_ld),
        .i_d   (w_mdr_d),
        .o_q   (w_mdr_q)
    );

    assign o_MAR       = w_mar_q;
    assign o_MDR       = w_mdr_q;
    assign o_Mem_Addr  = w_mar_q;
    assign o_Mem_WData = w_mdr_q;
    assign o_Mem_CE    = (r_state == ACCESS);
    assign o_Mem_WE    = (r_state == ACCESS) && (r_rw == MEM_WRITE);
    assign o_Busy      = !w_idle;
    assign o_Done      = (r_state == FINISH);
    assign o_Err       = (r_state == FINISH) && r_err;
    assign o_dbg_state = r_state;

endmodule

// File: doc/lc3_mem_ctrl.md
Name: lc3_mem_ctrl

Overview:
- Parametrised MAR/MDR pair with a memory-cycle state machine, replacing the fixed 16-bit MAR and MDR registers and the MDR input mux.
- Sits between the CPU bus and the SRAM/IO port. Control issues a one-cycle Req; the block drives the memory strobes and fills or drains MDR.
- Signals completion with a Done pulse.
- Supports two wait modes: fixed latency, or a memory Ready handshake with timeout.

Parameters:
- DATA_W, 16, bus/MDR/memory data width
- ADDR_W, 16, MAR/memory address width (ADDR_W <= DATA_W; MAR loads Bus_In[ADDR_W-1:0])
- WAIT_CYCLES, 2, ACCESS-state length in fixed mode; legal range 1..255
- USE_READY, 0, 0 = fixed latency, 1 = wait for Mem_Ready
- TIMEOUT, 64, maximum ACCESS cycles in Ready mode before error; legal range 1..255

Ports:
- Clk  in  1  clock; everything updates on the rising edge
- Reset  in  1  synchronous, active-high
- Bus_In  in  DATA_W  CPU bus value
- LD_MAR  in  1  load MAR from Bus_In
- LD_MDR  in  1  load MDR from Bus_In (CPU-side load)
- Req  in  1  start a memory cycle using the current MAR and MDR
- R_W  in  1  sampled with Req: 0 = read, 1 = write
- Mem_RData  in  DATA_W  memory read data
- Mem_Ready  in  1  memory ready (used only when USE_READY=1)
- MAR  out  ADDR_W  current address register
- MDR  out  DATA_W  current data register (feeds the GateMDR bus source)
- Mem_Addr  out  ADDR_W  equals MAR
- Mem_WData  out  DATA_W  equals MDR
- Mem_CE  out  1  chip enable
- Mem_WE  out  1  write enable
- Busy  out  1  FSM not in IDLE
- Done  out  1  one-cycle completion pulse
- Err  out  1  one-cycle timeout pulse, coincident with Done

Behaviour:
- Reset: MAR=0, MDR=0, state=IDLE, Mem_CE=0, Mem_WE=0, Busy=0, Done=0, Err=0, wait counter=0. Applies from any state; an in-flight access is abandoned and there is no Done.
- FSM states are IDLE, ACCESS and FINISH. All outputs are registered or decoded from the state; there is no combinational input-to-output path except Mem_Addr and Mem_WData, which are direct copies of MAR and MDR.
- IDLE:
  - LD_MAR loads MAR; LD_MDR loads MDR.
  - Req=1 latches R_W, clears the counter and moves to ACCESS.
  - If LD_* and Req are high in the same cycle, the loads take effect and the access uses the newly loaded values. This lets MAR<-Bus and the access start happen in one cycle.
- ACCESS:
  - Mem_CE=1, and Mem_WE=latched R_W.
  - The counter increments every cycle.
  - LD_MAR, LD_MDR and Req are ignored; MAR and MDR are frozen except for the read capture.
- Fixed mode (USE_READY=0):
  - ACCESS lasts exactly WAIT_CYCLES cycles.
  - On a read, MDR<=Mem_RData at the edge ending the last ACCESS cycle.
- Ready mode (USE_READY=1):
  - ACCESS ends at the first edge where Mem_Ready=1. On a read, MDR captures Mem_RData at that edge.
  - If Mem_Ready is still 0 after TIMEOUT cycles, the block moves to FINISH with an error flag. MDR is unchanged.
  - Mem_Ready=1 on the first ACCESS cycle is a legal 1-cycle access.
  - Mem_Ready in the same cycle the timeout count is reached counts as success, not timeout.
- FINISH:
  - Lasts one cycle: Done=1, Err=error flag, Mem_CE=0, Mem_WE=0, Busy=1.
  - Next state is IDLE.
  - Req in FINISH is ignored.
- Latency:
  - Req sampled at edge k gives ACCESS in cycles k+1..k+N and Done in cycle k+N+1.
  - N = WAIT_CYCLES in fixed mode; N = Ready arrival or TIMEOUT in Ready mode.
  - Throughput is one access per N+2 cycles.
- Writes: Mem_WData=MDR is stable for the whole ACCESS window; MDR is not modified.
- Widths: counter is 8 bits. The counter is compared against WAIT_CYCLES-1 or TIMEOUT-1; it never wraps because the maximum is 255.

Decomposition:
- Package lc3_mem_pkg holds:
  - the state typedef mem_state_t {IDLE, ACCESS, FINISH};
  - the constants MEM_READ=0 and MEM_WRITE=1;
  - CNT_W=8.
- One natural sub-module, lc3_ld_reg: a parametrised width-N load-enable register with synchronous reset, instantiated for MAR and MDR.
- The read-capture path into MDR is a priority mux in front of the MDR lc3_ld_reg: memory capture first, then LD_MDR.

Test Plan:
- Reset, then LD_MAR with Bus_In=16'h3000 -> MAR=16'h3000; Mem_CE=0, Busy=0, MDR=0.
- Fixed read, WAIT_CYCLES=2, MAR=16'h3000, Mem_RData=16'hBEEF, Req/R_W=0 at edge k -> Mem_CE=1 in k+1..k+2, MDR=16'hBEEF in k+3, Done=1 only in k+3.
- Fixed write, LD_MDR with 16'h1234 then Req/R_W=1 -> Mem_WE=1 and Mem_WData=16'h1234 for 2 cycles; MDR stays 16'h1234; Done after.
- Ready mode, Mem_Ready asserted on the 4th ACCESS cycle, Mem_RData=16'h00FF -> MDR=16'h00FF, Done=1, Err=0. Separately, Mem_Ready held 0 with TIMEOUT=64 -> Done=Err=1 at cycle k+65 and MDR unchanged.
- During ACCESS, drive LD_MAR with 16'hFFFF and a second Req -> MAR unchanged, no second access; Busy falls exactly one cycle after Done.
- Assert Reset in the 2nd ACCESS cycle -> next cycle Mem_CE=0, MAR=MDR=0, Busy=0, and no Done pulse occurs.
